// File: rtl/mac_pkg.sv
// Shared types and default sizing for the sparse MAC row datapath and its sequencer.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam int NZ_DEF      = 8;
    localparam int BW_DEF      = 4;
    localparam int PSUM_BW_DEF = 20;
    localparam int COL_DEF     = 4;

endpackage

// File: rtl/mac_row_seq_cnt.sv
// Loadable down-counter with zero and last (==1) flags.
// Latency: load/decrement visible the cycle after the request.
// Backpressure: none; the caller never decrements at zero, so the count never wraps.
module mac_row_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign last = (cnt == W'(1));

endmodule

// File: rtl/mac_row_seq.sv
// Job sequencer for one sparse MAC row; optional perf counters under MAC_ROW_SEQ_PERF_EN.
// Latency: start@t0 -> load@t1 -> acts from t2 -> psum_valid at t2+num_act+DRAIN_LAT+1 (plus stalls).
// Backpressure: act_valid low stalls the stream; result is held in DONE until psum_ready.
module mac_row_seq
    import mac_pkg::*;
#(
    parameter int nz        = NZ_DEF,
    parameter int bw        = BW_DEF,
    parameter int psum_bw   = PSUM_BW_DEF,
    parameter int col       = COL_DEF,
    parameter int CNT_BW    = 8,
    parameter int DRAIN_LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_BW-1:0]      num_act,
    input  logic [nz*bw-1:0]       wgt_flat,
    input  logic [nz*2-1:0]        widx_flat,
    input  logic [col*psum_bw-1:0] seed_psum_flat,
    input  logic                   act_valid,
    output logic                   act_ready,
    input  logic [2*bw-1:0]        act_data,
    input  logic [3:0]             act_idx,
    output logic                   busy,
    output logic                   row_load,
    output logic                   row_a_select,
    output logic                   row_execute,
    output logic [nz*bw-1:0]       row_wgt_flat,
    output logic [nz*2-1:0]        row_widx_flat,
    output logic [col*psum_bw-1:0] row_psum_flat,
    output logic [2*bw-1:0]        row_act_flat,
    output logic [3:0]             row_aidx_flat,
    input  logic [col*psum_bw-1:0] row_final_psum,
    output logic                   psum_valid,
    input  logic                   psum_ready,
    output logic [col*psum_bw-1:0] psum_out
`ifdef MAC_ROW_SEQ_PERF_EN
    ,
    output logic [31:0]            perf_busy_cyc,
    output logic [31:0]            perf_stall_cyc
`endif
);

    localparam int DW = $clog2(DRAIN_LAT + 2);

    state_t state, state_nxt;
    logic   job_take, capture, accept, exec_q;
    logic   rem_dec, rem_zero, rem_last;
    logic   drn_load, drn_dec, drn_zero, drn_last;

    mac_row_seq_cnt #(.W(CNT_BW)) u_rem (
        .clk      (clk),
        .reset    (reset),
        .load     (job_take),
        .load_val (num_act),
        .dec      (rem_dec),
        .zero     (rem_zero),
        .last     (rem_last)
    );

    // Loaded with DRAIN_LAT+1 and left on last, so DRAIN spans DRAIN_LAT+1 cycles.
    mac_row_seq_cnt #(.W(DW)) u_drn (
        .clk      (clk),
        .reset    (reset),
        .load     (drn_load),
        .load_val (DW'(DRAIN_LAT + 1)),
        .dec      (drn_dec),
        .zero     (drn_zero),
        .last     (drn_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b1;
        act_ready    = 1'b0;
        row_load     = 1'b0;
        row_a_select = 1'b0;
        psum_valid   = 1'b0;
        job_take     = 1'b0;
        capture      = 1'b0;
        rem_dec      = 1'b0;
        drn_load     = 1'b0;
        drn_dec      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    job_take  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                row_load     = 1'b1;
                row_a_select = 1'b1;
                if (rem_zero) begin
                    drn_load  = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                act_ready = 1'b1;
                if (act_valid) begin
                    rem_dec = 1'b1;
                    if (rem_last) begin
                        drn_load  = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drn_dec = !drn_zero;
                if (drn_last) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                psum_valid = 1'b1;
                if (psum_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept      = act_valid && act_ready;
    // Execute follows each accepted pair by one cycle, aligned with the act register.
    assign row_execute = (state == LOAD) || exec_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            exec_q        <= 1'b0;
            row_wgt_flat  <= '0;
            row_widx_flat <= '0;
            row_psum_flat <= '0;
            row_act_flat  <= '0;
            row_aidx_flat <= '0;
            psum_out      <= '0;
        end else begin
            exec_q <= accept;
            if (job_take) begin
                row_wgt_flat  <= wgt_flat;
                row_widx_flat <= widx_flat;
                row_psum_flat <= seed_psum_flat;
            end
            if (accept) begin
                row_act_flat  <= act_data;
                row_aidx_flat <= act_idx;
            end
            if (capture) begin
                psum_out <= row_final_psum;
            end
        end
    end

`ifdef MAC_ROW_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && perf_busy_cyc != '1) begin
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            end
            if (state == STREAM && !act_valid && perf_stall_cyc != '1) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mac_row_seq.sv
// Bench for mac_row_seq: table of directed jobs plus random jobs, with a stand-in mac_row.
// Build with MAC_ROW_SEQ_PERF_EN defined to also check the perf counters.
module tb_mac_row_seq;

    localparam int PW = 80;

    logic          clk = 1'b0;
    logic          reset, start, act_valid, psum_ready;
    logic [7:0]    num_act;
    logic [31:0]   wgt_flat;
    logic [15:0]   widx_flat;
    logic [PW-1:0] seed_psum_flat;
    logic          act_ready, busy, row_load, row_a_select, row_execute, psum_valid;
    logic [7:0]    act_data, row_act_flat;
    logic [3:0]    act_idx, row_aidx_flat;
    logic [31:0]   row_wgt_flat;
    logic [15:0]   row_widx_flat;
    logic [PW-1:0] row_psum_flat, row_final_psum, psum_out;
`ifdef MAC_ROW_SEQ_PERF_EN
    logic [31:0]   perf_busy_cyc, perf_stall_cyc;
`endif

    always #5 clk = ~clk;

    mac_row_seq dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_act        (num_act),
        .wgt_flat       (wgt_flat),
        .widx_flat      (widx_flat),
        .seed_psum_flat (seed_psum_flat),
        .act_valid      (act_valid),
        .act_ready      (act_ready),
        .act_data       (act_data),
        .act_idx        (act_idx),
        .busy           (busy),
        .row_load       (row_load),
        .row_a_select   (row_a_select),
        .row_execute    (row_execute),
        .row_wgt_flat   (row_wgt_flat),
        .row_widx_flat  (row_widx_flat),
        .row_psum_flat  (row_psum_flat),
        .row_act_flat   (row_act_flat),
        .row_aidx_flat  (row_aidx_flat),
        .row_final_psum (row_final_psum),
        .psum_valid     (psum_valid),
        .psum_ready     (psum_ready),
        .psum_out       (psum_out)
`ifdef MAC_ROW_SEQ_PERF_EN
        ,
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    // Product of one activation pair with the two weights its index pair selects.
    function automatic int pair_prod(input logic [7:0] d, input logic [3:0] ix, input logic [31:0] w);
        return int'(d[3:0]) * int'(w[ix[1:0]*4 +: 4]) + int'(d[7:4]) * int'(w[(ix[3:2]+4)*4 +: 4]);
    endfunction

    // Stand-in mac_row: seeds on load, accumulates lane c by (c+1)*product, one output stage.
    logic [PW-1:0] acc = '0;
    logic [PW-1:0] acc_nxt;
    always_comb begin
        acc_nxt = acc;
        if (row_load) begin
            acc_nxt = row_psum_flat;
        end else if (row_execute) begin
            for (int c = 0; c < 4; c++)
                acc_nxt[c*20 +: 20] = acc[c*20 +: 20] + 20'(pair_prod(row_act_flat, row_aidx_flat, row_wgt_flat) * (c + 1));
        end
    end
    always @(posedge clk) begin
        acc            <= acc_nxt;
        row_final_psum <= acc;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_act_ready"}, act_ready, 1'b0);
        chk({tag, "_row_load"}, row_load, 1'b0);
        chk({tag, "_row_a_select"}, row_a_select, 1'b0);
        chk({tag, "_row_execute"}, row_execute, 1'b0);
        chk({tag, "_psum_valid"}, psum_valid, 1'b0);
        chk({tag, "_psum_out"}, psum_out, '0);
        chk({tag, "_row_wgt"}, row_wgt_flat, '0);
        chk({tag, "_row_widx"}, row_widx_flat, '0);
        chk({tag, "_row_psum"}, row_psum_flat, '0);
        chk({tag, "_row_act"}, row_act_flat, '0);
        chk({tag, "_row_aidx"}, row_aidx_flat, '0);
`ifdef MAC_ROW_SEQ_PERF_EN
        chk({tag, "_perf_busy"}, perf_busy_cyc, '0);
        chk({tag, "_perf_stall"}, perf_stall_cyc, '0);
`endif
    endtask

    // Runs one job from a start pulse (driven at a negedge) to its result handshake.
    task automatic run_job(input int n, input int sa, input int sl, input int rd, input bit sid,
                           input bit sor, input int exp_lat, input int abort_at, input bit fixed_w);
        logic [PW-1:0] seed, expv;
        logic [95:0]   r96;
        logic [31:0]   wf;
        logic [15:0]   xf;
        logic [7:0]    qd[$];
        logic [3:0]    qi[$];
        int            c, loads, execs, readies, stall_left, acc_cnt, sl_eff, s;
`ifdef MAC_ROW_SEQ_PERF_EN
        logic [31:0]   st0;
`endif
        for (int i = 0; i < 8; i++)
            wf[i*4 +: 4] = fixed_w ? 4'(i + 1) : 4'($urandom_range(0, 15));
        xf             = 16'($urandom());
        r96            = {$urandom(), $urandom(), $urandom()};
        seed           = r96[PW-1:0];
        sl_eff         = (sa < n) ? sl : 0;
        num_act        = 8'(n);
        wgt_flat       = wf;
        widx_flat      = xf;
        seed_psum_flat = seed;
        start          = 1'b1;
`ifdef MAC_ROW_SEQ_PERF_EN
        st0 = perf_stall_cyc;
`endif
        @(negedge clk);
        start = 1'b0;
        num_act = 8'($urandom());
        wgt_flat = $urandom();
        seed_psum_flat = '0;
        c = 1;
        chk("load_at_t1", row_load, 1'b1);
        chk("a_select_at_t1", row_a_select, 1'b1);
        chk("execute_at_t1", row_execute, 1'b1);
        chk("ready_in_load", act_ready, 1'b0);
        chk("wgt_copy", row_wgt_flat, wf);
        chk("widx_copy", row_widx_flat, xf);
        chk("psum_copy", row_psum_flat, seed);
        loads = 0; execs = 0; readies = 0; acc_cnt = 0; stall_left = sl;
        while (!psum_valid && c < 700) begin
            if (row_load) loads++;
            if (row_execute && !row_load) execs++;
            if (act_ready) begin
                readies++;
                if (acc_cnt == abort_at) begin
                    reset = 1'b1;
                    act_valid = 1'b0;
                    @(negedge clk);
                    chk_all_zero("abort");
                    reset = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        act_valid = 1'($urandom());
                        @(negedge clk);
                        chk("abort_no_valid", psum_valid, 1'b0);
                        chk("abort_idle", busy, 1'b0);
                    end
                    act_valid = 1'b0;
                    return;
                end
                if (acc_cnt == sa && stall_left > 0) begin
                    act_valid = 1'b0;
                    stall_left--;
                end else begin
                    act_valid = 1'b1;
                    act_data  = 8'($urandom());
                    act_idx   = 4'($urandom());
                    qd.push_back(act_data);
                    qi.push_back(act_idx);
                    acc_cnt++;
                end
            end else begin
                act_valid = 1'($urandom());
                act_data  = 8'($urandom());
                act_idx   = 4'($urandom());
            end
            @(negedge clk);
            c++;
        end
        act_valid = 1'b0;
        s = 0;
        foreach (qd[i]) s += pair_prod(qd[i], qi[i], wf);
        for (int l = 0; l < 4; l++)
            expv[l*20 +: 20] = seed[l*20 +: 20] + 20'(s * (l + 1));
        chk("psum_valid_cycle", c, exp_lat);
        chk("load_cycles", loads, 1);
        chk("execute_cycles", execs, n);
        chk("handshakes", acc_cnt, n);
        chk("ready_cycles", readies, n + sl_eff);
        chk("psum_out", psum_out, expv);
`ifdef MAC_ROW_SEQ_PERF_EN
        chk("perf_stall", perf_stall_cyc - st0, sl_eff);
`endif
        for (int k = 0; k < rd; k++) begin
            psum_ready = 1'b0;
            start = sid && (k == 1);
            @(negedge clk);
            start = 1'b0;
            chk("held_valid", psum_valid, 1'b1);
            chk("held_psum", psum_out, expv);
        end
        psum_ready = 1'b1;
        start = sor;
        @(negedge clk);
        psum_ready = 1'b0;
        start = 1'b0;
        chk("valid_drop", psum_valid, 1'b0);
        chk("idle_after_done", busy, 1'b0);
    endtask

    typedef struct {
        int n, sa, sl, rd;
        bit sid, sor;
        int lat, abort_at;
        bit fixed_w;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n, sa, sl, rd;
        tbl[0] = '{3,   0, 0, 0, 1'b0, 1'b0, 8,   -1, 1'b1};
        tbl[1] = '{4,   2, 2, 0, 1'b0, 1'b0, 11,  -1, 1'b0};
        tbl[2] = '{0,   0, 0, 0, 1'b0, 1'b0, 5,   -1, 1'b0};
        tbl[3] = '{2,   0, 0, 5, 1'b1, 1'b0, 7,   -1, 1'b0};
        tbl[4] = '{5,   0, 0, 0, 1'b0, 1'b0, 0,    2, 1'b0};
        tbl[5] = '{1,   0, 0, 0, 1'b0, 1'b1, 6,   -1, 1'b0};
        tbl[6] = '{3,   1, 1, 2, 1'b0, 1'b0, 9,   -1, 1'b0};
        tbl[7] = '{255, 0, 0, 0, 1'b0, 1'b0, 260, -1, 1'b0};

        reset = 1'b1; start = 1'b0; act_valid = 1'b0; psum_ready = 1'b0;
        num_act = '0; wgt_flat = '0; widx_flat = '0; seed_psum_flat = '0;
        act_data = '0; act_idx = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        psum_ready = 1'b1;
        @(negedge clk);
        chk("ready_ignored_idle", psum_valid, 1'b0);
        psum_ready = 1'b0;

        foreach (tbl[i])
            run_job(tbl[i].n, tbl[i].sa, tbl[i].sl, tbl[i].rd, tbl[i].sid, tbl[i].sor,
                    tbl[i].lat, tbl[i].abort_at, tbl[i].fixed_w);

        for (int j = 0; j < 25; j++) begin
            n  = $urandom_range(0, 12);
            sa = $urandom_range(0, 12);
            sl = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            run_job(n, sa, sl, rd, 1'($urandom()), 1'($urandom()),
                    5 + n + ((sa < n) ? sl : 0), -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
